// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the controller state encoding and the default operand width.
package serial_adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/half_adder_cell.sv
// Single-bit half adder; two of these plus an OR gate form the serial full adder.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands load on start, then one bit is added
// LSB-first per enabled clock through a half-adder-pair full adder.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] w_a_sr_d;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] w_b_sr_d;
    logic [WIDTH-1:0] r_res_sr;
    logic [WIDTH-1:0] w_res_sr_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_carry;
    logic             w_carry_d;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_sum_d;
    logic             r_cout;
    logic             w_cout_d;

    logic             w_p;
    logic             w_g0;
    logic             w_g1;
    logic             w_s;
    logic             w_c_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res_shift;

    // Full adder: propagate/generate from the operand bits, then fold in the carry.
    half_adder_cell u_ha_op (
        .a (r_a_sr[0]),
        .b (r_b_sr[0]),
        .s (w_p),
        .c (w_g0)
    );

    half_adder_cell u_ha_carry (
        .a (w_p),
        .b (r_carry),
        .s (w_s),
        .c (w_g1)
    );

    assign w_c_next    = w_g0 | w_g1;
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_res_shift = {w_s, r_res_sr[WIDTH-1:1]};

    always_comb begin
        w_state_d  = r_state;
        w_a_sr_d   = r_a_sr;
        w_b_sr_d   = r_b_sr;
        w_res_sr_d = r_res_sr;
        w_cnt_d    = r_cnt;
        w_carry_d  = r_carry;
        w_sum_d    = r_sum;
        w_cout_d   = r_cout;

        if (ena) begin
            unique case (r_state)
                IDLE, DONE: begin
                    // A start in DONE chains straight into the next addition.
                    if (start) begin
                        w_a_sr_d   = a;
                        w_b_sr_d   = b;
                        w_res_sr_d = '0;
                        w_cnt_d    = '0;
                        w_carry_d  = 1'b0;
                        w_state_d  = SHIFT;
                    end else begin
                        w_state_d  = IDLE;
                    end
                end
                SHIFT: begin
                    w_a_sr_d   = r_a_sr >> 1;
                    w_b_sr_d   = r_b_sr >> 1;
                    w_res_sr_d = w_res_shift;
                    w_carry_d  = w_c_next;
                    w_cnt_d    = r_cnt + CNT_W'(1);
                    if (w_last) begin
                        w_sum_d   = w_res_shift;
                        w_cout_d  = w_c_next;
                        w_state_d = DONE;
                    end
                end
                default: begin
                    w_state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_a_sr   <= w_a_sr_d;
            r_b_sr   <= w_b_sr_d;
            r_res_sr <= w_res_sr_d;
            r_cnt    <= w_cnt_d;
            r_carry  <= w_carry_d;
            r_sum    <= w_sum_d;
            r_cout   <= w_cout_d;
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl; expected {cout,sum} values are
// queued on each accepted start and compared when done appears.
module tb_serial_adder_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] exp_q[$];
    logic [8:0] last_res = '0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] op_a, input logic [7:0] op_b, input bit push);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (push) exp_q.push_back({1'b0, op_a} + {1'b0, op_b});
    endtask

    // Scoreboard consumer: waits for done, checks latency, hold behaviour and result.
    task automatic wait_done(input string name, input int exp_lat);
        int         n = 0;
        int         hold_bad = 0;
        logic [8:0] exp_v;
        while (done !== 1'b1 && n < 200) begin
            if (busy !== 1'b1 || {cout, sum} !== last_res) hold_bad++;
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, n);
            return;
        end
        checks++;
        if (n != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, n, exp_lat);
        end
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL %s_hold: %0d busy cycles with busy!=1 or result not held at %h",
                     name, hold_bad, last_res);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_result: got %h, required nothing (queue empty)", name, {cout, sum});
        end else begin
            exp_v = exp_q.pop_front();
            if ({cout, sum} !== exp_v) begin
                errors++;
                $display("FAIL %s_result: got {cout,sum}=%h, required %h", name, {cout, sum}, exp_v);
            end
            last_res = exp_v;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        start = 1'b1;
        a     = 8'h35;
        b     = 8'h4A;
        tick();
        tick();
        checks++;
        if ({busy, done, cout, sum} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b cout=%b sum=%h, required all 0",
                     busy, done, cout, sum);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_start: busy=%b done=%b, required 0 0", busy, done);
        end
        last_res = '0;
    endtask

    task automatic test_basic();
        start_op(8'h35, 8'h4A, 1'b1);
        wait_done("basic", WIDTH);
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: done=%b busy=%b one cycle later, required 0 0", done, busy);
        end
    endtask

    task automatic test_overflow();
        start_op(8'hFF, 8'h01, 1'b1);
        wait_done("ovf_ff_01", WIDTH);
        tick();
        start_op(8'h80, 8'h80, 1'b1);
        wait_done("ovf_80_80", WIDTH);
        tick();
        start_op(8'hFF, 8'hFF, 1'b1);
        wait_done("ovf_ff_ff", WIDTH);
        tick();
    endtask

    task automatic test_busy_ignore();
        start_op(8'h10, 8'h20, 1'b1);
        tick();
        tick();
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_ignore", WIDTH - 3);
        tick();
    endtask

    task automatic test_done_restart();
        start_op(8'h01, 8'h02, 1'b1);
        wait_done("restart_first", WIDTH);
        start_op(8'h12, 8'h34, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_accept: busy=%b after start in DONE, required 1", busy);
        end
        wait_done("restart_second", WIDTH);
        tick();
    endtask

    task automatic test_stall();
        start_op(8'h99, 8'h66, 1'b1);
        tick();
        tick();
        tick();
        ena = 1'b0;
        repeat (5) tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: busy=%b done=%b while stalled, required 1 0", busy, done);
        end
        ena = 1'b1;
        wait_done("stall", WIDTH - 3);
        tick();
    endtask

    task automatic test_abort();
        int seen_done = 0;
        start_op(8'h12, 8'h34, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy, done, cout, sum} !== 11'b0) begin
            errors++;
            $display("FAIL abort_clear: busy=%b done=%b cout=%b sum=%h, required all 0",
                     busy, done, cout, sum);
        end
        repeat (12) begin
            tick();
            if (done === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done cycles, required 0", seen_done);
        end
        last_res = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            start_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
            wait_done("random", WIDTH);
        end
        tick();
        checks++;
        if (done !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: done=%b queue=%0d, required 0 0", done, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_busy_ignore();
        test_done_restart();
        test_stall();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial WIDTH-bit adder. It is the sequential stage directly downstream of the team's half-adder cell and replaces a parallel combinational adder.
- Operands are loaded on a start pulse and added LSB-first, one bit per enabled clock, through a full adder built from two half-adder cells plus a carry flip-flop.
- It sits inside the tt_um top and is driven from ui_in/uio_in. Results go to uo_out.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..16).
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; do not override).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- ena, input, 1, global enable; low freezes all state.
- start, input, 1, load request; sampled only when ena=1.
- a, input, WIDTH, operand A; captured when start is accepted.
- b, input, WIDTH, operand B; captured when start is accepted.
- busy, output, 1, high while the addition is in progress.
- done, output, 1, single-cycle pulse marking that the result is valid.
- sum, output, WIDTH, registered result (a+b) mod 2^WIDTH.
- cout, output, 1, registered carry-out of the MSB.

Behaviour:
- Reset: clock and reset are fixed as one clock, clk; synchronous active-low reset, rst_n.
  - rst_n=0 sampled at a clk edge forces state=IDLE and clears the shift registers, counter and carry.
  - Outputs after reset: busy=0, done=0, sum=0, cout=0.
- FSM states: IDLE, SHIFT, DONE. All state changes require ena=1; with ena=0 every register holds, including done.
- IDLE:
  - start=1 latches a and b into shift registers, clears carry and counter, and moves to SHIFT.
  - sum and cout keep their old values.
- SHIFT (busy=1), on each enabled edge:
  - s = a_sr[0] ^ b_sr[0] ^ c, computed as two cascaded half adders.
  - c_next = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & c).
  - a_sr and b_sr shift right; s shifts into the MSB of res_sr; counter increments.
  - When counter reaches WIDTH-1 on that edge: sum <= final res_sr, cout <= c_next, state moves to DONE.
- DONE: done=1 and busy=0 for exactly one enabled cycle, then return to IDLE.
  - start=1 while in DONE is accepted, as in IDLE. The next state is SHIFT, done still pulses this cycle.
- Latency: start accepted at edge E0 gives busy=1 for WIDTH cycles. done=1 and sum/cout are valid after edge E_WIDTH, so done is visible WIDTH cycles after acceptance.
- Result holding: sum and cout hold until the next completion. They do not change during SHIFT.
- start while busy=1 is ignored: no reload and no error.
- Reset during SHIFT aborts immediately. No done pulse is produced and sum/cout clear to 0.
- ena dropping mid-SHIFT stalls without losing state. Completion is delayed by the number of ena=0 cycles.
- Overflow: the sum wraps modulo 2^WIDTH and cout carries the lost bit (e.g. WIDTH=8: 255+1 gives sum=0, cout=1).

Decomposition:
- Package serial_adder_pkg holds:
  - the state enum type (IDLE, SHIFT, DONE), 2 bits;
  - default WIDTH constant 8.
- Sub-module half_adder_cell (a, b -> s = a^b, c = a&b), instantiated twice to form the full adder.
- Carry OR, shift registers, counter and FSM stay in serial_adder_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, sum=0x00, cout=0; no start accepted.
- Basic add: a=0x35, b=0x4A, start for 1 cycle -> busy for 8 cycles, then done pulse with sum=0x7F, cout=0.
- Overflow: a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF -> sum=0xFE, cout=1.
- Busy and DONE behaviour:
  - Start a=0x10, b=0x20. Pulse start again at cycle 3 with a=0xFF, b=0xFF -> ignored; result sum=0x30, cout=0.
  - Start asserted during the DONE cycle -> new operands are accepted.
- Stall and abort:
  - Drop ena for 5 cycles mid-SHIFT -> done arrives 5 cycles late; sum correct for a=0x99, b=0x66 (0xFF, cout=0).
  - rst_n=0 mid-SHIFT -> no done pulse, sum=0.
- Random: 500 random a/b pairs, back-to-back starts -> each done matches {cout,sum} = a+b.
